// File: rtl/umi_messages_pkg.sv
// Shared UMI message definitions: opcodes, cmd field offsets, the cmd builder and field extractors.
package umi_messages_pkg;

  localparam int unsigned CmdW = 32;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned SizeLsb   = 5;
  localparam int unsigned LenLsb    = 8;
  localparam int unsigned QosLsb    = 16;
  localparam int unsigned ProtLsb   = 20;
  localparam int unsigned EomBit    = 22;
  localparam int unsigned EofBit    = 23;
  localparam int unsigned ErrLsb    = 24;

  typedef enum logic [1:0] {
    RegErrOk      = 2'b00,
    RegErrIllegal = 2'b01,
    RegErrResp    = 2'b10,
    RegErrTimeout = 2'b11
  } reg_err_e;

  // QOS stays zero; EOF is always set because every request is a single-beat message.
  function automatic logic [CmdW-1:0] build_cmd(input logic [4:0] opcode,
                                                input logic [2:0] size,
                                                input logic [7:0] len,
                                                input logic [1:0] prot,
                                                input logic       eom);
    logic [CmdW-1:0] cmd;
    cmd                    = '0;
    cmd[OpcodeLsb +: 5]    = opcode;
    cmd[SizeLsb +: 3]      = size;
    cmd[LenLsb +: 8]       = len;
    cmd[ProtLsb +: 2]      = prot;
    cmd[EomBit]            = eom;
    cmd[EofBit]            = 1'b1;
    return cmd;
  endfunction

  function automatic logic [4:0] cmd_opcode(input logic [CmdW-1:0] cmd);
    return cmd[OpcodeLsb +: 5];
  endfunction

  function automatic logic [1:0] cmd_err(input logic [CmdW-1:0] cmd);
    return cmd[ErrLsb +: 2];
  endfunction

endpackage

// File: rtl/umi_reg_host_if.sv
// UMI host port: one request channel out of the host, one response channel back into it.
interface umi_reg_host_if #(
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 256
);
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_cmd;
  logic [AW-1:0] req_dstaddr;
  logic [AW-1:0] req_srcaddr;
  logic [DW-1:0] req_data;

  logic          resp_valid;
  logic          resp_ready;
  logic [CW-1:0] resp_cmd;
  logic [AW-1:0] resp_dstaddr;
  logic [AW-1:0] resp_srcaddr;
  logic [DW-1:0] resp_data;

  modport master (
    output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
  );
endinterface

// File: rtl/umi_reg_host.sv
// Register-bus to UMI host bridge: one outstanding single-beat read or write, with response
// matching, UMI error reporting and an optional response timeout.
module umi_reg_host
  import umi_messages_pkg::*;
#(
  parameter int unsigned CW      = 32,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 256,
  parameter int unsigned RW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW-1:0] host_srcaddr_i,
  input  logic          reg_read_i,
  input  logic          reg_write_i,
  input  logic [AW-1:0] reg_addr_i,
  input  logic [RW-1:0] reg_wrdata_i,
  input  logic [1:0]    reg_prot_i,
  output logic          reg_ready_o,
  output logic          reg_done_o,
  output logic [RW-1:0] reg_rddata_o,
  output logic [1:0]    reg_err_o,
  umi_reg_host_if.master uhost
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [2:0] SizeEnc = 3'($clog2(RW / 8));

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e        state_q;
  logic          is_write_q;
  logic [CntW-1:0] cnt_q;
  logic          req_valid_q;
  logic [CW-1:0] req_cmd_q;
  logic [AW-1:0] req_dstaddr_q;
  logic [AW-1:0] req_srcaddr_q;
  logic [DW-1:0] req_data_q;
  logic          resp_ready_q;
  logic          done_q;
  logic [RW-1:0] rddata_q;
  logic [1:0]    err_q;

  logic          resp_fire;
  logic          resp_match;
  logic          tmo_hit;
  logic [4:0]    exp_resp_op;
  logic          unused_resp;

  assign exp_resp_op = is_write_q ? RESP_WRITE : RESP_READ;
  assign resp_fire   = uhost.resp_valid & resp_ready_q;
  assign resp_match  = resp_fire && (uhost.resp_dstaddr == host_srcaddr_i) &&
                       (cmd_opcode(uhost.resp_cmd[CmdW-1:0]) == exp_resp_op);
  assign tmo_hit     = (TIMEOUT != 0) && (cnt_q == CntLast);
  assign unused_resp = ^{uhost.resp_srcaddr, uhost.resp_data, uhost.resp_cmd};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StIdle;
      is_write_q    <= 1'b0;
      cnt_q         <= '0;
      req_valid_q   <= 1'b0;
      req_cmd_q     <= '0;
      req_dstaddr_q <= '0;
      req_srcaddr_q <= '0;
      req_data_q    <= '0;
      resp_ready_q  <= 1'b0;
      done_q        <= 1'b0;
      rddata_q      <= '0;
      err_q         <= RegErrOk;
    end else begin
      // Responses are always drained; anything outside StResp is simply dropped.
      resp_ready_q <= 1'b1;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (reg_read_i && reg_write_i) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            err_q    <= RegErrIllegal;
            rddata_q <= '0;
          end else if (reg_read_i || reg_write_i) begin
            state_q       <= StReq;
            is_write_q    <= reg_write_i;
            req_valid_q   <= 1'b1;
            req_cmd_q     <= CW'(build_cmd(reg_write_i ? REQ_WRITE : REQ_READ, SizeEnc, 8'h00,
                                           reg_prot_i, 1'b1));
            req_dstaddr_q <= reg_addr_i;
            req_srcaddr_q <= host_srcaddr_i;
            req_data_q    <= reg_write_i ? DW'(reg_wrdata_i) : '0;
          end
        end
        StReq: begin
          if (uhost.req_ready) begin
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StResp;
          end
        end
        StResp: begin
          // A match wins over expiry on the same cycle.
          if (resp_match) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            err_q    <= (cmd_err(uhost.resp_cmd[CmdW-1:0]) != 2'b00) ? RegErrResp : RegErrOk;
            rddata_q <= is_write_q ? '0 : uhost.resp_data[RW-1:0];
          end else if (tmo_hit) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            err_q    <= RegErrTimeout;
            rddata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign reg_ready_o       = (state_q == StIdle);
  assign reg_done_o        = done_q;
  assign reg_rddata_o      = rddata_q;
  assign reg_err_o         = err_q;
  assign uhost.req_valid   = req_valid_q;
  assign uhost.req_cmd     = req_cmd_q;
  assign uhost.req_dstaddr = req_dstaddr_q;
  assign uhost.req_srcaddr = req_srcaddr_q;
  assign uhost.req_data    = req_data_q;
  assign uhost.resp_ready  = resp_ready_q;

endmodule
